// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, operand select, load-use
// interlock, write-through bypass and a valid/ready ID/EX register. Rev 1.0
`default_nettype none

module id_stage_pipe #(
  parameter int WORD     = 32,
  parameter int NREG     = 32,
  parameter int LU_STALL = 1,
  parameter int SEXT_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] instruction,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [WORD-1:0] wb_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [3:0]      alu_op,
  output logic            mem_r,
  output logic            mem_w,
  output logic            fwd_wb_en,
  output logic            terminate,
  output logic [4:0]      reg_rs,
  output logic [4:0]      reg_rt,
  output logic [4:0]      reg_dest,
  output logic [WORD-1:0] alu_1_data,
  output logic [WORD-1:0] alu_2_data,
  output logic [WORD-1:0] st_data,
  output logic [WORD-1:0] branch_offset,
  output logic [WORD-1:0] jump_address,
  output logic [1:0]      stall_cnt
);

  localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [1:0] LU_RELOAD = (LU_STALL > 0) ? 2'(LU_STALL - 1) : 2'd0;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic            mem_r;
    logic            mem_w;
    logic            wb;
    logic            term;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [WORD-1:0] a1;
    logic [WORD-1:0] a2;
    logic [WORD-1:0] sd;
    logic [WORD-1:0] bo;
    logic [WORD-1:0] ja;
  } out_t;

  logic [31:0]     ins_w;
  logic [WORD-1:0] jaddr_w;

  if (WORD >= 32) begin : g_ins_wide
    assign ins_w = instruction[31:0];
  end else begin : g_ins_narrow
    assign ins_w = {{(32-WORD){1'b0}}, instruction};
  end

  if (WORD > 26) begin : g_jmp_wide
    assign jaddr_w = {{(WORD-26){1'b0}}, ins_w[25:0]};
  end else begin : g_jmp_narrow
    assign jaddr_w = ins_w[WORD-1:0];
  end

  logic [5:0]  op_w, fn_w;
  logic [4:0]  rs_w, rt_w, rd_w, sh_w;
  logic [15:0] imm_w;

  assign op_w  = ins_w[31:26];
  assign rs_w  = ins_w[25:21];
  assign rt_w  = ins_w[20:16];
  assign rd_w  = ins_w[15:11];
  assign sh_w  = ins_w[10:6];
  assign fn_w  = ins_w[5:0];
  assign imm_w = ins_w[15:0];

  // Control unit
  logic [3:0] cu_alu_w;
  logic       cu_memr_w, cu_memw_w, cu_wb_w, cu_term_w, cu_shamt_w, cu_immd_w, ctrl_stall_w;

  always_comb begin
    cu_alu_w   = ALU_ADD;
    cu_memr_w  = 1'b0;
    cu_memw_w  = 1'b0;
    cu_wb_w    = 1'b0;
    cu_term_w  = 1'b0;
    cu_shamt_w = 1'b0;
    cu_immd_w  = 1'b0;
    case (op_w)
      6'h00: begin
        cu_wb_w = 1'b1;
        case (fn_w)
          6'h20: cu_alu_w = ALU_ADD;
          6'h22: cu_alu_w = ALU_SUB;
          6'h24: cu_alu_w = ALU_AND;
          6'h25: cu_alu_w = ALU_OR;
          6'h26: cu_alu_w = ALU_XOR;
          6'h27: cu_alu_w = ALU_NOR;
          6'h2A: cu_alu_w = ALU_SLT;
          6'h00: begin cu_alu_w = ALU_SLL; cu_shamt_w = 1'b1; end
          6'h02: begin cu_alu_w = ALU_SRL; cu_shamt_w = 1'b1; end
          6'h03: begin cu_alu_w = ALU_SRA; cu_shamt_w = 1'b1; end
          default: cu_wb_w = 1'b0;
        endcase
      end
      6'h08: begin cu_alu_w = ALU_ADD; cu_wb_w = 1'b1; cu_immd_w = 1'b1; end
      6'h0A: begin cu_alu_w = ALU_SLT; cu_wb_w = 1'b1; cu_immd_w = 1'b1; end
      6'h0C: begin cu_alu_w = ALU_AND; cu_wb_w = 1'b1; cu_immd_w = 1'b1; end
      6'h0D: begin cu_alu_w = ALU_OR;  cu_wb_w = 1'b1; cu_immd_w = 1'b1; end
      6'h0E: begin cu_alu_w = ALU_XOR; cu_wb_w = 1'b1; cu_immd_w = 1'b1; end
      6'h0F: begin cu_alu_w = ALU_LUI; cu_wb_w = 1'b1; cu_immd_w = 1'b1; end
      6'h23: begin cu_alu_w = ALU_ADD; cu_wb_w = 1'b1; cu_immd_w = 1'b1; cu_memr_w = 1'b1; end
      6'h2B: begin cu_alu_w = ALU_ADD; cu_immd_w = 1'b1; cu_memw_w = 1'b1; end
      6'h04, 6'h05: cu_alu_w = ALU_SUB;
      6'h3F: cu_term_w = 1'b1;
      default: ;
    endcase
  end

  // Register file: combinational reads with write-through, negedge write
  logic [WORD-1:0] rf_q [NREG];
  logic [IDXW-1:0] rs_idx_w, rt_idx_w, wb_idx_w;
  logic            wb_ok_w;
  logic [WORD-1:0] rs_val_w, rt_val_w;

  assign rs_idx_w = rs_w[IDXW-1:0];
  assign rt_idx_w = rt_w[IDXW-1:0];
  assign wb_idx_w = wb_dest[IDXW-1:0];
  assign wb_ok_w  = wb_en && (wb_idx_w != '0);

  assign rs_val_w = (rs_idx_w == '0) ? '0 :
                    (wb_ok_w && wb_idx_w == rs_idx_w) ? wb_data : rf_q[rs_idx_w];
  assign rt_val_w = (rt_idx_w == '0) ? '0 :
                    (wb_ok_w && wb_idx_w == rt_idx_w) ? wb_data : rf_q[rt_idx_w];

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_ok_w) begin
      rf_q[wb_idx_w] <= wb_data;
    end
  end

  logic [WORD-1:0] ext_w, sh_data_w;
  logic [4:0]      rs_used_w, rt_used_w, dest_w;

  always_comb begin
    ext_w       = {WORD{(SEXT_EN != 0) & imm_w[15]}};
    ext_w[15:0] = imm_w;
    sh_data_w      = '0;
    sh_data_w[4:0] = sh_w;
  end

  assign rs_used_w = cu_shamt_w ? 5'd0 : rs_w;
  assign rt_used_w = cu_immd_w  ? 5'd0 : rt_w;
  assign dest_w    = cu_immd_w  ? rt_w : rd_w;

  out_t       out_q, out_d;
  logic       valid_q, valid_d;
  logic [1:0] stall_q, stall_d;
  logic       hazard_w, busy_w, take_w;

  assign hazard_w = (LU_STALL != 0) && valid_q && out_q.mem_r && (out_q.rd != 5'd0) &&
                    ((out_q.rd == rs_used_w) || (out_q.rd == rt_used_w));
  assign busy_w       = (stall_q != 2'd0);
  assign ctrl_stall_w = hazard_w | busy_w;
  assign in_ready     = rst && !busy_w && !hazard_w && (!valid_q || out_ready);
  assign take_w       = in_valid && in_ready && !flush;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    stall_d = stall_q;
    if (flush) begin
      valid_d = 1'b0;
      stall_d = 2'd0;
    end else if (take_w) begin
      valid_d      = 1'b1;
      out_d.alu_op = ctrl_stall_w ? 4'd0 : cu_alu_w;
      out_d.mem_r  = cu_memr_w & ~ctrl_stall_w;
      out_d.mem_w  = cu_memw_w & ~ctrl_stall_w;
      out_d.wb     = cu_wb_w   & ~ctrl_stall_w;
      out_d.term   = cu_term_w & ~ctrl_stall_w;
      out_d.rs     = rs_used_w;
      out_d.rt     = rt_used_w;
      out_d.rd     = dest_w;
      out_d.a1     = cu_shamt_w ? sh_data_w : rs_val_w;
      out_d.a2     = cu_immd_w ? ext_w : rt_val_w;
      out_d.sd     = rt_val_w;
      out_d.bo     = ext_w;
      out_d.ja     = jaddr_w;
    end else begin
      if (valid_q && out_ready) valid_d = 1'b0;
      // The load leaving for EX opens the bubble window for its consumer
      if (valid_q && out_ready && hazard_w) stall_d = LU_RELOAD;
      else if (busy_w)                      stall_d = stall_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= 2'd0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid     = valid_q;
  assign alu_op        = out_q.alu_op;
  assign mem_r         = out_q.mem_r;
  assign mem_w         = out_q.mem_w;
  assign fwd_wb_en     = out_q.wb;
  assign terminate     = out_q.term;
  assign reg_rs        = out_q.rs;
  assign reg_rt        = out_q.rt;
  assign reg_dest      = out_q.rd;
  assign alu_1_data    = out_q.a1;
  assign alu_2_data    = out_q.a2;
  assign st_data       = out_q.sd;
  assign branch_offset = out_q.bo;
  assign jump_address  = out_q.ja;
  assign stall_cnt     = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and randomized checks of id_stage_pipe against
// an instruction-level reference model. Rev 1.0
`default_nettype none

module tb_id_stage_pipe;
  localparam int NREG = 16;
  localparam int LU   = 2;

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [31:0] instruction = '0, wb_data = '0;
  logic [4:0]  wb_dest = '0;

  logic        in_ready, out_valid, mem_r, mem_w, fwd_wb_en, terminate;
  logic [3:0]  alu_op;
  logic [4:0]  reg_rs, reg_rt, reg_dest;
  logic [31:0] alu_1_data, alu_2_data, st_data, branch_offset, jump_address;
  logic [1:0]  stall_cnt;

  logic        z_in_ready, z_out_valid, z_mem_r, z_mem_w, z_fwd_wb_en, z_terminate;
  logic [3:0]  z_alu_op;
  logic [4:0]  z_reg_rs, z_reg_rt, z_reg_dest;
  logic [31:0] z_alu_1_data, z_alu_2_data, z_st_data, z_branch_offset, z_jump_address;
  logic [1:0]  z_stall_cnt;

  always #5 clk = ~clk;

  id_stage_pipe #(.WORD(32), .NREG(NREG), .LU_STALL(LU), .SEXT_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .out_ready(out_ready),
    .out_valid(out_valid), .alu_op(alu_op), .mem_r(mem_r), .mem_w(mem_w), .fwd_wb_en(fwd_wb_en),
    .terminate(terminate), .reg_rs(reg_rs), .reg_rt(reg_rt), .reg_dest(reg_dest),
    .alu_1_data(alu_1_data), .alu_2_data(alu_2_data), .st_data(st_data),
    .branch_offset(branch_offset), .jump_address(jump_address), .stall_cnt(stall_cnt));

  id_stage_pipe #(.WORD(32), .NREG(32), .LU_STALL(0), .SEXT_EN(0)) u_dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .instruction(instruction),
    .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .out_ready(out_ready),
    .out_valid(z_out_valid), .alu_op(z_alu_op), .mem_r(z_mem_r), .mem_w(z_mem_w),
    .fwd_wb_en(z_fwd_wb_en), .terminate(z_terminate), .reg_rs(z_reg_rs), .reg_rt(z_reg_rt),
    .reg_dest(z_reg_dest), .alu_1_data(z_alu_1_data), .alu_2_data(z_alu_2_data),
    .st_data(z_st_data), .branch_offset(z_branch_offset), .jump_address(z_jump_address),
    .stall_cnt(z_stall_cnt));

  typedef struct packed {
    logic [3:0]  aop;
    logic        mr, mw, wb, term;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a1, a2, sd, bo, ja;
  } exp_t;

  int          tests = 0, fails = 0;
  exp_t        m;
  bit          m_v;
  int          m_stall;
  logic [31:0] m_rf [NREG];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    int idx = int'(r) % NREG;
    int wi  = int'(wb_dest) % NREG;
    if (idx == 0) return 32'd0;
    if (wb_en && wi != 0 && wi == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] ins);
    exp_t e = '0;
    bit sh = 0, im = 0;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    case (op)
      6'h00: begin
        e.wb = 1;
        case (fn)
          6'h20: e.aop = 0;  6'h22: e.aop = 1;  6'h24: e.aop = 2;  6'h25: e.aop = 3;
          6'h26: e.aop = 4;  6'h27: e.aop = 5;  6'h2A: e.aop = 6;
          6'h00: begin e.aop = 7; sh = 1; end
          6'h02: begin e.aop = 8; sh = 1; end
          6'h03: begin e.aop = 9; sh = 1; end
          default: e.wb = 0;
        endcase
      end
      6'h08: begin e.aop = 0;  e.wb = 1; im = 1; end
      6'h0A: begin e.aop = 6;  e.wb = 1; im = 1; end
      6'h0C: begin e.aop = 2;  e.wb = 1; im = 1; end
      6'h0D: begin e.aop = 3;  e.wb = 1; im = 1; end
      6'h0E: begin e.aop = 4;  e.wb = 1; im = 1; end
      6'h0F: begin e.aop = 10; e.wb = 1; im = 1; end
      6'h23: begin e.aop = 0;  e.wb = 1; im = 1; e.mr = 1; end
      6'h2B: begin e.aop = 0;  e.mw = 1; im = 1; end
      6'h04, 6'h05: e.aop = 1;
      6'h3F: e.term = 1;
      default: ;
    endcase
    e.bo = {{16{ins[15]}}, ins[15:0]};
    e.ja = {6'd0, ins[25:0]};
    e.rs = sh ? 5'd0 : ins[25:21];
    e.rt = im ? 5'd0 : ins[20:16];
    e.rd = im ? ins[20:16] : ins[15:11];
    e.a1 = sh ? {27'd0, ins[10:6]} : m_read(ins[25:21]);
    e.a2 = im ? e.bo : m_read(ins[20:16]);
    e.sd = m_read(ins[20:16]);
    return e;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, m_v);
    chk("alu_op", alu_op, m.aop);
    chk("mem_r", mem_r, m.mr);
    chk("mem_w", mem_w, m.mw);
    chk("fwd_wb_en", fwd_wb_en, m.wb);
    chk("terminate", terminate, m.term);
    chk("reg_rs", reg_rs, m.rs);
    chk("reg_rt", reg_rt, m.rt);
    chk("reg_dest", reg_dest, m.rd);
    chk("alu_1_data", alu_1_data, m.a1);
    chk("alu_2_data", alu_2_data, m.a2);
    chk("st_data", st_data, m.sd);
    chk("branch_offset", branch_offset, m.bo);
    chk("jump_address", jump_address, m.ja);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  // One clock: check handshake, advance the model, check the registered outputs
  task automatic tick();
    exp_t d;
    bit   hz, rdy;
    int   wi;
    d   = m_decode(instruction);
    hz  = (LU != 0) && m_v && m.mr && m.rd != 0 && (m.rd == d.rs || m.rd == d.rt);
    rdy = (m_stall == 0) && !hz && (!m_v || out_ready);
    #1;
    chk("in_ready", in_ready, rdy);
    if (flush) begin
      m_v = 0;
      m_stall = 0;
    end else if (in_valid && rdy) begin
      m   = d;
      m_v = 1;
    end else begin
      if (m_v && out_ready && hz) m_stall = LU - 1;
      else if (m_stall > 0)       m_stall = m_stall - 1;
      if (m_v && out_ready) m_v = 0;
    end
    wi = int'(wb_dest) % NREG;
    if (wb_en && wi != 0) m_rf[wi] = wb_data;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
    tick();
  endtask

  task automatic do_reset();
    rst = 0; in_valid = 0; flush = 0; wb_en = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    m = '0; m_v = 0; m_stall = 0;
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    check_outputs();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_z_valid", z_out_valid, 1'b0);
    rst = 1;
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [10] = '{6'h08, 6'h0A, 6'h0C, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h02};
    logic [5:0] fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h11};
    logic [31:0] w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 0) begin
      w[31:26] = 6'h00;
      w[5:0]   = fns[$urandom_range(0, 10)];
    end else begin
      w[31:26] = ops[$urandom_range(0, 9)];
    end
    return w;
  endfunction

  logic [31:0] snap_a1;

  initial begin
    do_reset();

    step(1, i_ins(6'h08, 5'd1, 5'd0, 16'hFFFF), 1, 0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_sext", alu_2_data, 32'hFFFF_FFFF);
    chk("addi_dest", reg_dest, 5'd1);
    chk("addi_rt_tag", reg_rt, 5'd0);
    chk("addi_zext", z_alu_2_data, 32'h0000_FFFF);
    chk("addi_zext_bo", z_branch_offset, 32'h0000_FFFF);

    wb_en = 1; wb_dest = 5'd5; wb_data = 32'h1234;
    step(1, r_ins(6'h20, 5'd3, 5'd5, 5'd0), 1, 0);
    chk("wt_a1", alu_1_data, 32'h1234);
    wb_en = 0;
    step(1, r_ins(6'h20, 5'd3, 5'd0, 5'd5), 1, 0);
    chk("rf_a2", alu_2_data, 32'h1234);
    wb_en = 1; wb_dest = 5'd0; wb_data = 32'hDEAD_BEEF;
    step(1, r_ins(6'h20, 5'd3, 5'd0, 5'd0), 1, 0);
    chk("r0_wt", alu_1_data, 32'd0);
    wb_en = 0;
    step(1, r_ins(6'h20, 5'd3, 5'd0, 5'd0), 1, 0);
    chk("r0_read", alu_1_data, 32'd0);
    wb_en = 1; wb_dest = 5'd17; wb_data = 32'hABCD;
    step(1, r_ins(6'h20, 5'd3, 5'd1, 5'd0), 1, 0);
    chk("mod_wt", alu_1_data, 32'hABCD);
    wb_en = 0;

    snap_a1 = alu_1_data;
    for (int k = 0; k < 3; k++) begin
      step(1, r_ins(6'h22, 5'd9, 5'd5, 5'd1), 0, 0);
      chk("bp_hold_a1", alu_1_data, snap_a1);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    step(1, r_ins(6'h22, 5'd9, 5'd5, 5'd1), 1, 0);
    chk("bp_release_dest", reg_dest, 5'd9);

    step(1, i_ins(6'h23, 5'd2, 5'd1, 16'd4), 1, 0);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 1, 0);
    chk("lu_bubble1_valid", out_valid, 1'b0);
    chk("lu_bubble1_cnt", stall_cnt, 2'd1);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 1, 0);
    chk("lu_bubble2_valid", out_valid, 1'b0);
    chk("lu_bubble2_cnt", stall_cnt, 2'd0);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 1, 0);
    chk("lu_issue_valid", out_valid, 1'b1);
    chk("lu_issue_dest", reg_dest, 5'd4);
    step(1, i_ins(6'h23, 5'd2, 5'd1, 16'd8), 1, 0);
    step(1, r_ins(6'h20, 5'd4, 5'd6, 5'd7), 1, 0);
    chk("nolu_valid", out_valid, 1'b1);
    chk("nolu_rs", reg_rs, 5'd6);

    step(1, r_ins(6'h25, 5'd7, 5'd1, 5'd1), 1, 0);
    step(1, r_ins(6'h22, 5'd8, 5'd1, 5'd1), 0, 1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_not_taken", reg_dest, 5'd7);

    step(1, i_ins(6'h23, 5'd2, 5'd1, 16'd0), 1, 0);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 1, 0);
    chk("pre_rst_cnt", stall_cnt, 2'd1);
    #1 rst = 0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_cnt", stall_cnt, 2'd0);
    chk("arst_in_ready", in_ready, 1'b0);
    do_reset();

    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      wb_en       = 1'($urandom_range(0, 1));
      wb_dest     = 5'($urandom_range(0, 20));
      wb_data     = $urandom;
      instruction = rand_ins();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
